// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
package pic_pkg;

  // Handshake states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PEND  = 3'd1,
    ACK1  = 3'd2,
    WAIT2 = 3'd3,
    ACK2  = 3'd4
  } state_t;

  // OCW2 {R, SL, EOI} codes that request an end of interrupt
  localparam logic [2:0] OCW2_EOI_NONSPEC = 3'b001;
  localparam logic [2:0] OCW2_EOI_SPEC    = 3'b011;
  localparam logic [2:0] OCW2_ROT_NONSPEC = 3'b101;
  localparam logic [2:0] OCW2_ROT_SPEC    = 3'b111;

  // Level reported when the request vanished before the first INTA
  localparam logic [2:0] SPUR_LEVEL_DEF = 3'd7;

  // Index of the lowest set bit; the resolver guarantees one-hot input
  function automatic logic [2:0] encode_onehot(input logic [7:0] v);
    logic [2:0] enc;
    enc = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) enc = 3'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/pic_rot_scan.sv
// Finds the first set bit of vec, scanning upward from rot with mod-8 wrap.
module pic_rot_scan (
  input  logic [7:0] vec,
  input  logic [2:0] rot,
  output logic       found,
  output logic [2:0] level
);

  logic [2:0] w_idx;

  // Walk from the lowest priority back to rot so the last hit is the winner
  always_comb begin
    found = 1'b0;
    level = 3'd0;
    w_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      w_idx = rot + 3'(i);
      if (vec[w_idx]) begin
        found = 1'b1;
        level = w_idx;
      end
    end
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// CPU-side INT/INTA sequencer for the 8259-style controller (8086 mode).
//
// state | meaning
// IDLE  | no request outstanding, INT low
// PEND  | INT high, waiting for the first INTA
// ACK1  | first INTA low, ISR set, waiting for its rising edge
// WAIT2 | between the two INTA pulses
// ACK2  | second INTA low, vector byte driven on the bus
module interrupt_ack_sequencer
  import pic_pkg::*;
#(
  parameter int         NUM_IR     = 8,
  parameter logic [2:0] SPUR_LEVEL = SPUR_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_IR-1:0] interrupt_vector,
  input  logic              inta_n,
  input  logic [4:0]        vector_base,
  input  logic              auto_eoi,
  input  logic              eoi_cmd,
  input  logic              eoi_specific,
  input  logic              eoi_rotate,
  input  logic [2:0]        eoi_level,
  output logic              int_o,
  output logic [7:0]        data_out,
  output logic              data_out_en,
  output logic [7:0]        isr,
  output logic [7:0]        clear_irr,
  output logic              freeze,
  output logic [2:0]        priority_rotate
);

  state_t     r_state, w_next;
  logic       r_inta_prev;
  logic [2:0] r_lvl;
  logic       r_spur;
  logic [7:0] r_isr;
  logic [7:0] r_clear_irr;
  logic [2:0] r_rot;

  logic       w_fall, w_rise, w_ack1, w_vec_none;
  logic [7:0] w_inta_set, w_aeoi_clr, w_eoi_clr;
  logic [2:0] w_ocw2, w_eoi_lvl;
  logic       w_is_spec, w_is_nonspec, w_eoi_hit;
  logic       w_scan_found;
  logic [2:0] w_scan_lvl;

  assign w_fall     = r_inta_prev & ~inta_n;
  assign w_rise     = ~r_inta_prev & inta_n;
  assign w_vec_none = (interrupt_vector == '0);
  assign w_ack1     = (r_state == PEND) && w_fall;

  pic_rot_scan u_scan (
    .vec   (r_isr),
    .rot   (r_rot),
    .found (w_scan_found),
    .level (w_scan_lvl)
  );

  // Handshake state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; INTA edges only matter once INT has been raised
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!w_vec_none) w_next = PEND;
      PEND:    if (w_fall)      w_next = ACK1;
      ACK1:    if (w_rise)      w_next = WAIT2;
      WAIT2:   if (w_fall)      w_next = ACK2;
      ACK2:    if (w_rise)      w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  // ISR set/clear masks and EOI decode, all against the pre-edge ISR
  always_comb begin
    w_inta_set   = 8'h00;
    w_aeoi_clr   = 8'h00;
    w_eoi_clr    = 8'h00;
    w_ocw2       = {eoi_rotate, eoi_specific, eoi_cmd};
    w_is_spec    = eoi_cmd && (w_ocw2 == OCW2_EOI_SPEC || w_ocw2 == OCW2_ROT_SPEC);
    w_is_nonspec = eoi_cmd && (w_ocw2 == OCW2_EOI_NONSPEC || w_ocw2 == OCW2_ROT_NONSPEC);
    w_eoi_lvl    = w_is_spec ? eoi_level : w_scan_lvl;
    w_eoi_hit    = 1'b0;
    if (w_ack1 && !w_vec_none)
      w_inta_set = 8'h01 << encode_onehot(interrupt_vector);
    if ((r_state == ACK2) && w_rise && auto_eoi && !r_spur)
      w_aeoi_clr = 8'h01 << r_lvl;
    if (w_is_spec) begin
      w_eoi_clr = 8'h01 << eoi_level;
      w_eoi_hit = r_isr[eoi_level];
    end else if (w_is_nonspec && w_scan_found) begin
      w_eoi_clr = 8'h01 << w_scan_lvl;
      w_eoi_hit = 1'b1;
    end
  end

  // Registered INTA copy for edge detection; idles high like the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_inta_prev <= 1'b1;
    else          r_inta_prev <= inta_n;
  end

  // Capture the acknowledged level at the first INTA
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl  <= 3'd0;
      r_spur <= 1'b0;
    end else if (w_ack1) begin
      r_lvl  <= w_vec_none ? SPUR_LEVEL : encode_onehot(interrupt_vector);
      r_spur <= w_vec_none;
    end
  end

  // ISR update; a same-cycle set wins over a clear of the same bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_isr <= 8'h00;
    else          r_isr <= (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_inta_set;
  end

  // One-cycle IRR clear pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_clear_irr <= 8'h00;
    else          r_clear_irr <= w_inta_set;
  end

  // Rotation only follows an EOI that really cleared an in-service bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     r_rot <= 3'd0;
    else if (eoi_rotate && w_eoi_hit) r_rot <= w_eoi_lvl + 3'd1;
  end

  assign int_o           = (r_state == PEND);
  assign freeze          = (r_state == ACK1) || (r_state == WAIT2) || (r_state == ACK2);
  assign data_out_en     = (r_state == ACK2);
  assign data_out        = data_out_en ? {vector_base, r_lvl} : 8'h00;
  assign isr             = r_isr;
  assign clear_irr       = r_clear_irr;
  assign priority_rotate = r_rot;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer.
module tb_interrupt_ack_sequencer;

  logic       clk;
  logic       reset_n;
  logic [7:0] interrupt_vector;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic       int_o;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [7:0] isr;
  logic [7:0] clear_irr;
  logic       freeze;
  logic [2:0] priority_rotate;

  int n_checks = 0;
  int n_errors = 0;

  interrupt_ack_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .interrupt_vector (interrupt_vector),
    .inta_n           (inta_n),
    .vector_base      (vector_base),
    .auto_eoi         (auto_eoi),
    .eoi_cmd          (eoi_cmd),
    .eoi_specific     (eoi_specific),
    .eoi_rotate       (eoi_rotate),
    .eoi_level        (eoi_level),
    .int_o            (int_o),
    .data_out         (data_out),
    .data_out_en      (data_out_en),
    .isr              (isr),
    .clear_irr        (clear_irr),
    .freeze           (freeze),
    .priority_rotate  (priority_rotate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic inta_fall();
    inta_n = 1'b0;
    tick(1);
  endtask

  task automatic inta_rise();
    inta_n = 1'b1;
    tick(1);
  endtask

  task automatic do_ack(input logic [7:0] v);
    interrupt_vector = v;
    tick(1);
    inta_fall();
    interrupt_vector = 8'h00;
    tick(1);
    inta_rise();
    tick(1);
    inta_fall();
    tick(1);
    inta_rise();
    tick(1);
  endtask

  task automatic eoi(input logic spec, input logic rot, input logic [2:0] lvl);
    eoi_specific = spec;
    eoi_rotate   = rot;
    eoi_level    = lvl;
    eoi_cmd      = 1'b1;
    tick(1);
    eoi_cmd      = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate   = 1'b0;
  endtask

  initial begin
    reset_n          = 1'b0;
    interrupt_vector = 8'h00;
    inta_n           = 1'b1;
    vector_base      = 5'h11;
    auto_eoi         = 1'b0;
    eoi_cmd          = 1'b0;
    eoi_specific     = 1'b0;
    eoi_rotate       = 1'b0;
    eoi_level        = 3'd0;
    #3;
    chk("rst int_o", 32'(int_o), 0);
    chk("rst data_out", 32'(data_out), 0);
    chk("rst data_out_en", 32'(data_out_en), 0);
    chk("rst isr", 32'(isr), 0);
    chk("rst clear_irr", 32'(clear_irr), 0);
    chk("rst freeze", 32'(freeze), 0);
    chk("rst rot", 32'(priority_rotate), 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // 1: normal two-pulse acknowledge of IR3
    interrupt_vector = 8'h08;
    chk("t1 idle int_o", 32'(int_o), 0);
    tick(1);
    chk("t1 pend int_o", 32'(int_o), 1);
    inta_fall();
    interrupt_vector = 8'h00;
    chk("t1 fall1 int_o", 32'(int_o), 0);
    chk("t1 fall1 freeze", 32'(freeze), 1);
    chk("t1 fall1 isr", 32'(isr), 8'h08);
    chk("t1 fall1 clear_irr", 32'(clear_irr), 8'h08);
    chk("t1 fall1 en", 32'(data_out_en), 0);
    tick(1);
    chk("t1 clear_irr pulse end", 32'(clear_irr), 0);
    inta_rise();
    chk("t1 rise1 freeze", 32'(freeze), 1);
    chk("t1 rise1 en", 32'(data_out_en), 0);
    tick(1);
    inta_fall();
    chk("t1 fall2 en", 32'(data_out_en), 1);
    chk("t1 fall2 data", 32'(data_out), 8'h8B);
    tick(1);
    chk("t1 hold en", 32'(data_out_en), 1);
    inta_rise();
    chk("t1 rise2 en", 32'(data_out_en), 0);
    chk("t1 rise2 data", 32'(data_out), 0);
    chk("t1 rise2 freeze", 32'(freeze), 0);
    chk("t1 rise2 isr kept", 32'(isr), 8'h08);
    eoi(1'b1, 1'b0, 3'd3);
    chk("t1 spec eoi isr", 32'(isr), 0);
    chk("t1 spec eoi rot", 32'(priority_rotate), 0);

    // 2: spurious acknowledge
    interrupt_vector = 8'h04;
    tick(1);
    interrupt_vector = 8'h00;
    tick(1);
    chk("t2 pend int_o", 32'(int_o), 1);
    inta_fall();
    chk("t2 fall1 isr", 32'(isr), 0);
    chk("t2 fall1 clear_irr", 32'(clear_irr), 0);
    chk("t2 fall1 freeze", 32'(freeze), 1);
    inta_rise();
    tick(1);
    inta_fall();
    chk("t2 spur data", 32'(data_out), 8'h8F);
    chk("t2 spur en", 32'(data_out_en), 1);
    inta_rise();
    chk("t2 end isr", 32'(isr), 0);

    // 3: non-specific EOI with rotate from rot=0
    do_ack(8'h04);
    do_ack(8'h20);
    chk("t3 isr before", 32'(isr), 8'h24);
    eoi(1'b0, 1'b1, 3'd0);
    chk("t3 isr after", 32'(isr), 8'h20);
    chk("t3 rot after", 32'(priority_rotate), 3);

    // non-specific EOI on an empty ISR leaves rotation alone
    eoi(1'b1, 1'b1, 3'd5);
    chk("t3b spec rot isr", 32'(isr), 0);
    chk("t3b spec rot rot", 32'(priority_rotate), 6);
    eoi(1'b0, 1'b1, 3'd0);
    chk("empty eoi isr", 32'(isr), 0);
    chk("empty eoi rot", 32'(priority_rotate), 6);

    // 4: wrap of the scan and of the rotation
    do_ack(8'h01);
    do_ack(8'h80);
    chk("t4 isr before", 32'(isr), 8'h81);
    eoi(1'b0, 1'b1, 3'd0);
    chk("t4 isr after", 32'(isr), 8'h01);
    chk("t4 rot after", 32'(priority_rotate), 0);
    eoi(1'b1, 1'b0, 3'd0);
    chk("t4 cleanup isr", 32'(isr), 0);

    // 5: automatic EOI
    auto_eoi = 1'b1;
    interrupt_vector = 8'h04;
    tick(1);
    inta_fall();
    interrupt_vector = 8'h00;
    chk("t5 fall1 isr", 32'(isr), 8'h04);
    inta_rise();
    tick(1);
    inta_fall();
    chk("t5 fall2 isr", 32'(isr), 8'h04);
    chk("t5 fall2 data", 32'(data_out), 8'h8A);
    inta_rise();
    chk("t5 rise2 isr", 32'(isr), 0);
    chk("t5 rot", 32'(priority_rotate), 0);
    auto_eoi = 1'b0;

    // set and specific clear of the same bit in one cycle
    interrupt_vector = 8'h10;
    tick(1);
    eoi_specific = 1'b1;
    eoi_level    = 3'd4;
    eoi_cmd      = 1'b1;
    inta_fall();
    eoi_cmd      = 1'b0;
    eoi_specific = 1'b0;
    interrupt_vector = 8'h00;
    chk("set wins isr", 32'(isr), 8'h10);
    inta_rise();
    tick(1);
    inta_fall();
    inta_rise();
    eoi(1'b1, 1'b1, 3'd4);
    chk("spec rot4 isr", 32'(isr), 0);
    chk("spec rot4 rot", 32'(priority_rotate), 5);

    // 6: reset during WAIT2
    interrupt_vector = 8'h02;
    tick(1);
    inta_fall();
    interrupt_vector = 8'h00;
    inta_rise();
    chk("t6 wait2 freeze", 32'(freeze), 1);
    chk("t6 wait2 isr", 32'(isr), 8'h02);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 rst freeze", 32'(freeze), 0);
    chk("t6 rst isr", 32'(isr), 0);
    chk("t6 rst rot", 32'(priority_rotate), 0);
    chk("t6 rst int_o", 32'(int_o), 0);
    chk("t6 rst en", 32'(data_out_en), 0);
    tick(1);
    reset_n = 1'b1;
    tick(2);
    inta_fall();
    chk("t6 late int_o", 32'(int_o), 0);
    chk("t6 late freeze", 32'(freeze), 0);
    chk("t6 late isr", 32'(isr), 0);
    chk("t6 late clear_irr", 32'(clear_irr), 0);
    inta_rise();
    tick(1);
    inta_fall();
    chk("t6 late en", 32'(data_out_en), 0);
    inta_rise();

    // reset in ACK2 drops the bus drive without a clock
    interrupt_vector = 8'h02;
    tick(1);
    inta_fall();
    interrupt_vector = 8'h00;
    inta_rise();
    tick(1);
    inta_fall();
    chk("ack2 en", 32'(data_out_en), 1);
    chk("ack2 data", 32'(data_out), 8'h89);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ack2 rst en", 32'(data_out_en), 0);
    chk("ack2 rst data", 32'(data_out), 0);
    inta_n = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
